// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, ALUOp/funct encodings and issue FSM states
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1111;
  localparam logic [1:0] ALUOP_LS  = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_IMM = 2'b11;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULW, S_HOLD} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: ALUOp/funct7/funct3 to 4-bit ALU control code, unsupported ops become add
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] code,
  output logic       illegal
);
  // map the op class and function fields onto an ALU code, flagging anything unknown
  always_comb begin
    code = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_LS: code = ALU_ADD;
      ALUOP_BR: code = ALU_SUB;
      ALUOP_R:
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: code = ALU_ADD;
          {F7_ALT, F3_ADD}:  code = ALU_SUB;
          {F7_BASE, F3_AND}: code = ALU_AND;
          {F7_BASE, F3_OR}:  code = ALU_OR;
          {F7_MUL, F3_ADD}:  code = ALU_MUL;
          default:           illegal = 1'b1;
        endcase
      default:
        case (funct3)
          F3_ADD:  code = ALU_ADD;
          F3_AND:  code = ALU_AND;
          F3_OR:   code = ALU_OR;
          default: illegal = 1'b1;
        endcase
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers decoded op and operands onto the ALU, waits its latency, hands result downstream
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       alu_op_i,
  input  logic [6:0]       funct7_i,
  input  logic [2:0]       funct3_i,
  input  logic             alu_src_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  input  logic [WIDTH-1:0] alu_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             busy_o
);
  state_t state, state_nx;
  logic [3:0] code_d, cnt;
  logic ill_d, ill_q, accept, capture;
  state_t issue_st;
  alu_ctrl_decode u_dec (
    .alu_op (alu_op_i),
    .funct7 (funct7_i),
    .funct3 (funct3_i),
    .code   (code_d),
    .illegal(ill_d)
  );
  assign in_ready_o  = state == S_IDLE || (state == S_HOLD && res_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign capture     = state == S_EXEC || (state == S_MULW && cnt == '0);
  assign res_valid_o = state == S_HOLD;
  assign busy_o      = state != S_IDLE;
  assign issue_st    = code_d == ALU_MUL ? S_MULW : S_EXEC;
  // state register; reset aborts any op in flight
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= S_IDLE;
    else state <= state_nx;
  // next state: issue from IDLE or straight out of HOLD when the result is taken
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = accept ? issue_st : S_IDLE;
      S_EXEC:  state_nx = S_HOLD;
      S_MULW:  state_nx = cnt == '0 ? S_HOLD : S_MULW;
      S_HOLD:  state_nx = accept ? issue_st : (res_ready_i ? S_IDLE : S_HOLD);
      default: state_nx = S_IDLE;
    endcase
  end
  // operands change only on accept so the ALU sees stable inputs for the whole op
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      alu_ctrl_o  <= '0;
      alu_data1_o <= '0;
      alu_data2_o <= '0;
      ill_q       <= 1'b0;
      cnt         <= '0;
    end else if (accept) begin
      alu_ctrl_o  <= code_d;
      alu_data1_o <= rs1_data_i;
      alu_data2_o <= alu_src_i ? imm_i : rs2_data_i;
      ill_q       <= ill_d;
      cnt         <= code_d == ALU_MUL ? 4'(MUL_CYCLES - 1) : '0;
    end else if (state == S_MULW && cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  // capture the ALU result once its latency has elapsed; held until the next capture
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      result_o  <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else if (capture) begin
      result_o  <= alu_data_i;
      zero_o    <= alu_data_i == '0;
      illegal_o <= ill_q;
    end
endmodule
